// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and sizing helpers for the serial pattern generator and its detector benches.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Width needed to hold 0..maxval, never narrower than one bit.
    function automatic int width_for(input int maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

    localparam int MAX_LEN      = 16;
    localparam int CLKS_PER_BIT = 1;
    localparam int LEN_W        = $clog2(MAX_LEN + 1);
    localparam int TICK_W       = $clog2(CLKS_PER_BIT + 1);

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Control/data bundle between a pattern-generator user (master) and the generator (slave).
interface seq_pattern_gen_if
    import seq_pkg::*;
#(
    parameter int MAX_LEN = 16
);
    localparam int LW = width_for(MAX_LEN);

    logic               start;
    logic               stop;
    logic [MAX_LEN-1:0] pattern;
    logic [LW-1:0]      len;
    logic               repeat_en;
    logic               w;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, pattern, len, repeat_en,
        input  w, busy, done
    );

    modport slave (
        input  start, stop, pattern, len, repeat_en,
        output w, busy, done
    );

endinterface

// File: rtl/seq_pattern_gen_bit_timer.sv
// Bit-period timer: strobes bit_tick on the last clock of every CLKS_PER_BIT-cycle bit period.
module bit_timer
    import seq_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic bit_tick
);
    localparam int TW = width_for(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] tick;

    assign bit_tick = en && (tick == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            tick <= '0;
        end else if (en) begin
            tick <= bit_tick ? '0 : tick + TW'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: shifts a latched pattern out on w, MSB of the valid length first,
// optionally looping with idle gap bits between passes.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int   MAX_LEN      = 16,
    parameter int   CLKS_PER_BIT = 1,
    parameter int   GAP_BITS     = 0,
    parameter logic IDLE_LEVEL   = 1'b0
) (
    input logic             clk,
    input logic             rst_n,
    seq_pattern_gen_if.slave bus
);
    localparam int LW = width_for(MAX_LEN);
    localparam int GW = width_for(GAP_BITS);
    localparam logic [LW-1:0] MAX_L    = LW'(MAX_LEN);
    localparam logic [LW-1:0] ONE      = LW'(1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    state_t             state, state_nx;
    logic [MAX_LEN-1:0] lat, lat_nx, sreg, sreg_nx;
    logic [LW-1:0]      len_lat, len_lat_nx, bit_cnt, bit_cnt_nx;
    logic [GW-1:0]      gap_cnt, gap_cnt_nx;
    logic               w_q, w_nx, busy_q, busy_nx, done_q, done_nx;

    logic [LW-1:0]      len_eff;
    logic [MAX_LEN-1:0] aligned;
    logic               accept, abort, bit_tick;

    // Left-justify the pattern so its first bit always sits in the MSB of the shift register.
    assign len_eff = (bus.len > MAX_L) ? MAX_L : bus.len;
    assign aligned = bus.pattern << (MAX_L - len_eff);
    assign accept  = (state == IDLE) && bus.start && !bus.stop && (len_eff != '0);
    assign abort   = (state != IDLE) && bus.stop;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept || abort),
        .en      (state != IDLE),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_nx   = state;
        lat_nx     = lat;
        len_lat_nx = len_lat;
        sreg_nx    = sreg;
        bit_cnt_nx = bit_cnt;
        gap_cnt_nx = gap_cnt;
        w_nx       = w_q;
        busy_nx    = busy_q;
        done_nx    = 1'b0;

        case (state)
            IDLE: begin
                w_nx    = IDLE_LEVEL;
                busy_nx = 1'b0;
                if (accept) begin
                    state_nx   = SHIFT;
                    lat_nx     = aligned;
                    len_lat_nx = len_eff;
                    sreg_nx    = aligned << 1;
                    w_nx       = aligned[MAX_LEN-1];
                    busy_nx    = 1'b1;
                    bit_cnt_nx = len_eff - ONE;
                end
            end
            SHIFT: begin
                if (bit_tick) begin
                    if (bit_cnt != '0) begin
                        bit_cnt_nx = bit_cnt - ONE;
                        w_nx       = sreg[MAX_LEN-1];
                        sreg_nx    = sreg << 1;
                    end else if (bus.repeat_en && (GAP_BITS > 0)) begin
                        state_nx   = GAP;
                        w_nx       = IDLE_LEVEL;
                        gap_cnt_nx = GAP_LAST;
                    end else if (bus.repeat_en) begin
                        w_nx       = lat[MAX_LEN-1];
                        sreg_nx    = lat << 1;
                        bit_cnt_nx = len_lat - ONE;
                    end else begin
                        state_nx = IDLE;
                        w_nx     = IDLE_LEVEL;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (bit_tick) begin
                    if (gap_cnt != '0) begin
                        gap_cnt_nx = gap_cnt - GW'(1);
                    end else begin
                        state_nx   = SHIFT;
                        w_nx       = lat[MAX_LEN-1];
                        sreg_nx    = lat << 1;
                        bit_cnt_nx = len_lat - ONE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                w_nx     = IDLE_LEVEL;
                busy_nx  = 1'b0;
            end
        endcase

        if (abort) begin
            state_nx   = IDLE;
            w_nx       = IDLE_LEVEL;
            busy_nx    = 1'b0;
            done_nx    = 1'b0;
            bit_cnt_nx = '0;
            gap_cnt_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            lat     <= '0;
            len_lat <= '0;
            sreg    <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            w_q     <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            lat     <= lat_nx;
            len_lat <= len_lat_nx;
            sreg    <= sreg_nx;
            bit_cnt <= bit_cnt_nx;
            gap_cnt <= gap_cnt_nx;
            w_q     <= w_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
        end
    end

    assign bus.w    = w_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: three configurations (plain, slow bit clock, repeat with gap).
module tb_seq_pattern_gen;

    logic clk;
    logic rst_n;

    seq_pattern_gen_if #(.MAX_LEN(16)) ifa ();
    seq_pattern_gen_if #(.MAX_LEN(16)) ifb ();
    seq_pattern_gen_if #(.MAX_LEN(16)) ifc ();

    seq_pattern_gen #(.MAX_LEN(16), .CLKS_PER_BIT(1), .GAP_BITS(0), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
    );
    seq_pattern_gen #(.MAX_LEN(16), .CLKS_PER_BIT(3), .GAP_BITS(0), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
    );
    seq_pattern_gen #(.MAX_LEN(16), .CLKS_PER_BIT(1), .GAP_BITS(2), .IDLE_LEVEL(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc.slave)
    );

    typedef struct {
        int    id;
        logic  w;
        logic  busy;
        logic  done;
        string name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expected entry per cycle, compared half a period after the edge it describes.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic aw, ab, ad;
            e = sb.pop_front();
            case (e.id)
                0:       begin aw = ifa.w; ab = ifa.busy; ad = ifa.done; end
                1:       begin aw = ifb.w; ab = ifb.busy; ad = ifb.done; end
                default: begin aw = ifc.w; ab = ifc.busy; ad = ifc.done; end
            endcase
            chk({e.name, ".w"},    aw, e.w);
            chk({e.name, ".busy"}, ab, e.busy);
            chk({e.name, ".done"}, ad, e.done);
        end
    end

    task automatic step(input int id, input logic ew, input logic eb, input logic ed, input string nm);
        @(posedge clk);
        #1;
        sb.push_back('{id, ew, eb, ed, nm});
        ifa.start = 1'b0; ifa.stop = 1'b0;
        ifb.start = 1'b0; ifb.stop = 1'b0;
        ifc.start = 1'b0; ifc.stop = 1'b0;
    endtask

    task automatic pass(input int id, input logic [15:0] bits, input int n, input int clks, input string nm);
        for (int i = n - 1; i >= 0; i--) begin
            repeat (clks) step(id, bits[i], 1'b1, 1'b0, nm);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ifa.start = 0; ifa.stop = 0; ifa.pattern = '0; ifa.len = '0; ifa.repeat_en = 0;
        ifb.start = 0; ifb.stop = 0; ifb.pattern = '0; ifb.len = '0; ifb.repeat_en = 0;
        ifc.start = 0; ifc.stop = 0; ifc.pattern = '0; ifc.len = '0; ifc.repeat_en = 0;

        step(0, 1'b0, 1'b0, 1'b0, "rst_a");
        step(1, 1'b0, 1'b0, 1'b0, "rst_b");
        step(2, 1'b1, 1'b0, 1'b0, "rst_c");
        rst_n = 1'b1;
        step(0, 1'b0, 1'b0, 1'b0, "idle_a");

        // Basic 11-bit pass, one clock per bit
        ifa.pattern = 16'h076A; ifa.len = 5'd11; ifa.start = 1'b1;
        pass(0, 16'h076A, 11, 1, "t1_bit");
        step(0, 1'b0, 1'b0, 1'b1, "t1_done");
        step(0, 1'b0, 1'b0, 1'b0, "t1_after");

        // Three clocks per bit
        ifb.pattern = 16'h000A; ifb.len = 5'd4; ifb.start = 1'b1;
        pass(1, 16'h000A, 4, 3, "t2_bit");
        step(1, 1'b0, 1'b0, 1'b1, "t2_done");
        step(1, 1'b0, 1'b0, 1'b0, "t2_after");

        // Repeat with two gap bits at idle level 1, then drop repeat_en in pass 3
        ifc.pattern = 16'h0005; ifc.len = 5'd3; ifc.repeat_en = 1'b1; ifc.start = 1'b1;
        pass(2, 16'h0005, 3, 1, "t3_p1");
        repeat (2) step(2, 1'b1, 1'b1, 1'b0, "t3_gap1");
        pass(2, 16'h0005, 3, 1, "t3_p2");
        repeat (2) step(2, 1'b1, 1'b1, 1'b0, "t3_gap2");
        step(2, 1'b1, 1'b1, 1'b0, "t3_p3");
        ifc.repeat_en = 1'b0;
        step(2, 1'b0, 1'b1, 1'b0, "t3_p3");
        step(2, 1'b1, 1'b1, 1'b0, "t3_p3");
        step(2, 1'b1, 1'b0, 1'b1, "t3_done");
        step(2, 1'b1, 1'b0, 1'b0, "t3_after");

        // Stop during the second bit of a 5-bit pass
        ifa.pattern = 16'h0016; ifa.len = 5'd5; ifa.start = 1'b1;
        step(0, 1'b1, 1'b1, 1'b0, "t4_b0");
        step(0, 1'b0, 1'b1, 1'b0, "t4_b1");
        ifa.stop = 1'b1;
        step(0, 1'b0, 1'b0, 1'b0, "t4_stop");
        repeat (3) step(0, 1'b0, 1'b0, 1'b0, "t4_nodone");

        // Ignored starts: len=0, while busy, together with stop
        ifa.pattern = 16'hFFFF; ifa.len = 5'd0; ifa.start = 1'b1;
        repeat (2) step(0, 1'b0, 1'b0, 1'b0, "t5_len0");
        ifa.pattern = 16'h0007; ifa.len = 5'd3; ifa.start = 1'b1;
        step(0, 1'b1, 1'b1, 1'b0, "t5_busy");
        ifa.pattern = 16'hFFFF; ifa.len = 5'd5; ifa.start = 1'b1;
        step(0, 1'b1, 1'b1, 1'b0, "t5_busy");
        step(0, 1'b1, 1'b1, 1'b0, "t5_busy");
        step(0, 1'b0, 1'b0, 1'b1, "t5_done");
        ifa.pattern = 16'h0001; ifa.len = 5'd2; ifa.start = 1'b1;
        step(0, 1'b0, 1'b1, 1'b0, "t5_rearm");
        step(0, 1'b1, 1'b1, 1'b0, "t5_rearm");
        step(0, 1'b0, 1'b0, 1'b1, "t5_rearm_done");
        ifa.pattern = 16'h0001; ifa.len = 5'd1; ifa.start = 1'b1; ifa.stop = 1'b1;
        repeat (2) step(0, 1'b0, 1'b0, 1'b0, "t5_startstop");

        // Reset mid-pass, then an over-long len clamped to 16
        ifa.pattern = 16'hFFFF; ifa.len = 5'd16; ifa.start = 1'b1;
        repeat (3) step(0, 1'b1, 1'b1, 1'b0, "t6_pre");
        rst_n = 1'b0;
        step(0, 1'b0, 1'b0, 1'b0, "t6_rst");
        rst_n = 1'b1;
        step(0, 1'b0, 1'b0, 1'b0, "t6_idle");
        ifa.pattern = 16'hA5C3; ifa.len = 5'd17; ifa.start = 1'b1;
        pass(0, 16'hA5C3, 16, 1, "t6_bit");
        step(0, 1'b0, 1'b0, 1'b1, "t6_done");
        step(0, 1'b0, 1'b0, 1'b0, "t6_after");

        repeat (3) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
